// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset vector, canonical NOP and the fetch entry layout.
package mips_pkg;

    localparam int unsigned AW_DEFAULT = 32;
    localparam int unsigned IW_DEFAULT = 32;

    localparam logic [AW_DEFAULT-1:0] RESET_PC  = 32'h0000_3000;
    localparam logic [IW_DEFAULT-1:0] INSTR_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [AW_DEFAULT-1:0] pc;
        logic [IW_DEFAULT-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_id_queue_mem.sv
// Entry storage for the IF/ID queue: one synchronous write port, one asynchronous read port.
module if_id_queue_mem #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset; validity is tracked by the occupancy count.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode queue: circular buffer with occupancy count and single-cycle flush.
module if_id_queue
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = AW_DEFAULT,
    parameter int unsigned IW    = IW_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_pc,
    input  logic [IW-1:0]            in_instr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [AW-1:0]            out_pc,
    output logic [AW-1:0]            out_pc4,
    output logic [IW-1:0]            out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop;
    logic [AW+IW-1:0] rdata;

    // Handshakes depend only on registered state and flush.
    assign in_ready  = (count_q != CntFull) && !flush;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    if_id_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (AW + IW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({in_pc, in_instr}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    assign out_pc    = rdata[AW+IW-1:IW];
    assign out_instr = rdata[IW-1:0];
    assign out_pc4   = out_pc + AW'(4);
    assign count     = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Randomised and directed bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;
    import mips_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_pc, in_instr, out_pc, out_pc4, out_instr;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    fetch_entry_t model_q[$];

    always #5 clk = ~clk;

    if_id_queue #(.DEPTH(DEPTH), .AW(32), .IW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_pc4   (out_pc4),
        .out_instr (out_instr),
        .count     (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of entries updated from the visible handshake rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
        end else if (flush) begin
            model_q.delete();
        end else begin
            int sz;
            fetch_entry_t e;
            sz = model_q.size();
            if (out_ready && sz > 0) void'(model_q.pop_front());
            if (in_valid && sz < DEPTH) begin
                e.pc    = in_pc;
                e.instr = in_instr;
                model_q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        int sz;
        sz = model_q.size();
        chk("count", 32'(count), 32'(sz));
        chk("out_valid", 32'(out_valid), 32'(sz != 0));
        chk("in_ready", 32'(in_ready), 32'((sz != DEPTH) && !flush));
        if (sz != 0) begin
            chk("out_pc", out_pc, model_q[0].pc);
            chk("out_pc4", out_pc4, model_q[0].pc + 32'd4);
            chk("out_instr", out_instr, model_q[0].instr);
        end
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, INSTR_NOP, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        #10 rst_n = 1'b1;

        // First push appears one cycle later with PC+4.
        drive(1'b1, RESET_PC, 32'h2008_0005, 1'b0, 1'b0);
        chk("t1_valid_same_cycle", 32'(out_valid), 32'd0);
        idle();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_pc", out_pc, 32'h3000);
        chk("t1_pc4", out_pc4, 32'h3004);
        chk("t1_instr", out_instr, 32'h2008_0005);
        chk("t1_count", 32'(count), 32'd1);

        // Fill to full, fifth push refused, drain in order.
        drive(1'b0, 32'h0, INSTR_NOP, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h3000 + 32'(4 * i), 32'h100 + 32'(i), 1'b0, 1'b0);
        idle();
        chk("t2_count_full", 32'(count), 32'd4);
        chk("t2_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h3010, 32'hDEAD, 1'b0, 1'b0);
        idle();
        chk("t2_count_after_fifth", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, INSTR_NOP, 1'b1, 1'b0);
            chk("t2_drain_pc", out_pc, 32'h3000 + 32'(4 * i));
        end
        idle();
        chk("t2_empty", 32'(count), 32'd0);

        // Streaming at count=1 with pointer wrap.
        drive(1'b1, 32'h3000, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h3004 + 32'(4 * i), 32'(i), 1'b1, 1'b0);
            chk("t3_count", 32'(count), 32'd1);
            chk("t3_pc", out_pc, 32'h3000 + 32'(4 * i));
        end
        drive(1'b0, 32'h0, INSTR_NOP, 1'b1, 1'b0);
        chk("t3_last_pc", out_pc, 32'h3040);

        // Flush of a full queue with a concurrent push.
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h5000 + 32'(4 * i), 32'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h6000, 32'h0, 1'b0, 1'b1);
        chk("t4_ready_in_flush", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h3040, 32'h0C00_0000, 1'b0, 1'b0);
        chk("t4_count", 32'(count), 32'd0);
        chk("t4_valid", 32'(out_valid), 32'd0);
        chk("t4_in_ready", 32'(in_ready), 32'd1);
        idle();
        chk("t4_head", out_pc, 32'h3040);

        // PC+4 wraps.
        drive(1'b0, 32'h0, INSTR_NOP, 1'b0, 1'b1);
        drive(1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
        idle();
        chk("t5_pc4_wrap", out_pc4, 32'h0000_0000);

        // Asynchronous reset between edges.
        drive(1'b0, 32'h0, INSTR_NOP, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h7000 + 32'(4 * i), 32'h0, 1'b0, 1'b0);
        idle();
        chk("t6_count3", 32'(count), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_count", 32'(count), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        drive(1'b1, RESET_PC, 32'h2008_0005, 1'b0, 1'b0);
        idle();
        chk("t6_after_rst_pc", out_pc, 32'h3000);
        chk("t6_after_rst_count", 32'(count), 32'd1);

        // Random traffic, checked every cycle by the compare process.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            drive(1'($urandom_range(0, 3) != 0), pc, $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end
        idle();
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
